// File: rtl/programmable_state_controller_pkg.sv
// Shared definitions for the table-driven state controller.
//   CFG_SEL_NS / CFG_SEL_OUT : values of cfg_sel selecting the next-state or output table
//   STATE_IDLE               : IDLE encoding of the one-hot state register (no bit set)
//   clog2()                  : ceiling log2, used to size state-index fields
package programmable_state_controller_pkg;

    localparam logic CFG_SEL_NS  = 1'b0;
    localparam logic CFG_SEL_OUT = 1'b1;

    localparam int unsigned MAX_STATES = 64;
    localparam logic [MAX_STATES-1:0] STATE_IDLE = '0;

    // clog2(1) = 0, clog2(7) = 3, clog2(16) = 4.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/programmable_state_controller_fsm_table_regs.sv
// Flop-based next-state (NS) and output (OUT) tables for the state controller.
// One write port, combinational read of NS[{rd_idx, rd_vz}] and OUT[rd_idx].
//   clock, clear     : clock and async active-low clear (all entries to zero)
//   we, sel          : write strobe; sel picks NS (CFG_SEL_NS) or OUT (CFG_SEL_OUT)
//   addr             : NS -> {state, vz}; OUT -> state in the low SIDX_W bits
//   wdata            : NS takes low SIDX_W bits, OUT takes low OUT_W bits
//   rd_idx, rd_vz    : read address (current state index and condition inputs)
//   ns_rdata         : raw NS entry, not range-checked here
//   out_rdata        : OUT entry for rd_idx
module programmable_state_controller_fsm_table_regs
    import programmable_state_controller_pkg::*;
#(
    parameter int unsigned NUM_STATES = 7,
    parameter int unsigned IN_W       = 2,
    parameter int unsigned OUT_W      = 5,
    parameter int unsigned SIDX_W     = 3,
    parameter int unsigned WDATA_W    = 5
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic                     we,
    input  logic                     sel,
    input  logic [SIDX_W+IN_W-1:0]   addr,
    input  logic [WDATA_W-1:0]       wdata,
    input  logic [SIDX_W-1:0]        rd_idx,
    input  logic [IN_W-1:0]          rd_vz,
    output logic [SIDX_W-1:0]        ns_rdata,
    output logic [OUT_W-1:0]         out_rdata
);

    localparam int unsigned NS_DEPTH = NUM_STATES << IN_W;
    // One extra bit so the bound check never degenerates to a constant.
    localparam logic [SIDX_W:0] STATE_LIMIT = (SIDX_W + 1)'(NUM_STATES);

    logic [SIDX_W-1:0] ns_table  [NS_DEPTH];
    logic [OUT_W-1:0]  out_table [NUM_STATES];

    logic [SIDX_W-1:0] ns_wstate;
    logic [SIDX_W-1:0] out_wstate;
    logic              ns_wr;
    logic              out_wr;

    assign ns_wstate  = addr[SIDX_W+IN_W-1:IN_W];
    assign out_wstate = addr[SIDX_W-1:0];

    // Writes aimed at a non-existent state are silently dropped.
    assign ns_wr  = we && (sel == CFG_SEL_NS)  && ({1'b0, ns_wstate}  < STATE_LIMIT);
    assign out_wr = we && (sel == CFG_SEL_OUT) && ({1'b0, out_wstate} < STATE_LIMIT);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < NS_DEPTH; i++) begin
                ns_table[i] <= '0;
            end
        end else if (ns_wr) begin
            ns_table[addr] <= wdata[SIDX_W-1:0];
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                out_table[i] <= '0;
            end
        end else if (out_wr) begin
            out_table[out_wstate] <= wdata[OUT_W-1:0];
        end
    end

    assign ns_rdata  = ns_table[{rd_idx, rd_vz}];
    assign out_rdata = out_table[rd_idx];

endmodule

// File: rtl/programmable_state_controller.sv
// Table-driven Moore FSM controller with runtime-programmable next-state and output tables.
//   clock           : rising-edge clock
//   clear           : async active-low reset; deassertion must be synchronous to clock
//   start           : enter state 0 (highest priority), clears error
//   enable          : 1 = take the table transition this edge, 0 = hold
//   vz              : condition inputs from the datapath
//   cfg_we/cfg_sel  : table write strobe / table select (NS or OUT)
//   cfg_addr        : NS -> {state, vz}; OUT -> state in low SIDX_W bits
//   cfg_wdata       : write data
//   controller_out  : control lines of the current state, 0 in IDLE
//   state_onehot    : one-hot current state, all-zero = IDLE
//   state_changed   : 1 for one cycle after an edge that changed the state
//   error           : sticky, set when an out-of-range NS entry is taken
module programmable_state_controller
    import programmable_state_controller_pkg::*;
#(
    parameter int unsigned NUM_STATES = 7,
    parameter int unsigned IN_W       = 2,
    parameter int unsigned OUT_W      = 5,
    localparam int unsigned SIDX_W    = clog2(NUM_STATES),
    localparam int unsigned WDATA_W   = (SIDX_W > OUT_W) ? SIDX_W : OUT_W
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic                     start,
    input  logic                     enable,
    input  logic [IN_W-1:0]          vz,
    input  logic                     cfg_we,
    input  logic                     cfg_sel,
    input  logic [SIDX_W+IN_W-1:0]   cfg_addr,
    input  logic [WDATA_W-1:0]       cfg_wdata,
    output logic [OUT_W-1:0]         controller_out,
    output logic [NUM_STATES-1:0]    state_onehot,
    output logic                     state_changed,
    output logic                     error
);

    localparam logic [SIDX_W:0]       STATE_LIMIT   = (SIDX_W + 1)'(NUM_STATES);
    localparam logic [NUM_STATES-1:0] START_ONEHOT  = NUM_STATES'(1);

    logic [NUM_STATES-1:0] state_q, state_d;
    logic                  changed_q, changed_d;
    logic                  error_q, error_d;

    logic [SIDX_W-1:0]     cur_idx;
    logic                  idle;
    logic [SIDX_W-1:0]     ns_rdata;
    logic [OUT_W-1:0]      out_rdata;
    logic                  ns_legal;

    programmable_state_controller_fsm_table_regs #(
        .NUM_STATES (NUM_STATES),
        .IN_W       (IN_W),
        .OUT_W      (OUT_W),
        .SIDX_W     (SIDX_W),
        .WDATA_W    (WDATA_W)
    ) u_tables (
        .clock     (clock),
        .clear     (clear),
        .we        (cfg_we),
        .sel       (cfg_sel),
        .addr      (cfg_addr),
        .wdata     (cfg_wdata),
        .rd_idx    (cur_idx),
        .rd_vz     (vz),
        .ns_rdata  (ns_rdata),
        .out_rdata (out_rdata)
    );

    // One-hot to index; IDLE encodes as index 0 but is masked wherever it matters.
    always_comb begin
        cur_idx = '0;
        for (int i = 0; i < NUM_STATES; i++) begin
            if (state_q[i]) begin
                cur_idx = cur_idx | SIDX_W'(i);
            end
        end
    end

    assign idle     = (state_q == STATE_IDLE[NUM_STATES-1:0]);
    assign ns_legal = ({1'b0, ns_rdata} < STATE_LIMIT);

    always_comb begin
        state_d = state_q;
        error_d = error_q;
        if (start) begin
            state_d = START_ONEHOT;
            error_d = 1'b0;
        end else if (!idle && enable) begin
            if (ns_legal) begin
                for (int i = 0; i < NUM_STATES; i++) begin
                    state_d[i] = (ns_rdata == SIDX_W'(i));
                end
            end else begin
                state_d = '0;
                error_d = 1'b1;
            end
        end
    end

    assign changed_d = (state_d != state_q);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q   <= '0;
            changed_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            changed_q <= changed_d;
            error_q   <= error_d;
        end
    end

    assign controller_out = idle ? '0 : out_rdata;
    assign state_onehot   = state_q;
    assign state_changed  = changed_q;
    assign error          = error_q;

endmodule

// File: tb/tb_programmable_state_controller.sv
module tb_programmable_state_controller;

    logic       clock = 1'b0;
    logic       clear = 1'b0;

    // Instance A: 7 states, 2 condition bits, 5 outputs.
    logic       start = 1'b0, enable = 1'b0;
    logic [1:0] vz = '0;
    logic       cfg_we = 1'b0, cfg_sel = 1'b0;
    logic [4:0] cfg_addr = '0;
    logic [4:0] cfg_wdata = '0;
    logic [4:0] controller_out;
    logic [6:0] state_onehot;
    logic       state_changed, error;

    // Instance B: 16 states, 3 condition bits, 8 outputs.
    logic       b_start = 1'b0, b_enable = 1'b0;
    logic [2:0] b_vz = '0;
    logic       b_cfg_we = 1'b0, b_cfg_sel = 1'b0;
    logic [6:0] b_cfg_addr = '0;
    logic [7:0] b_cfg_wdata = '0;
    logic [7:0]  b_out;
    logic [15:0] b_onehot;
    logic        b_chg, b_err;

    int total = 0;
    int bad   = 0;
    logic check_en = 1'b0;

    programmable_state_controller #(.NUM_STATES(7), .IN_W(2), .OUT_W(5)) dut (
        .clock(clock), .clear(clear), .start(start), .enable(enable), .vz(vz),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .controller_out(controller_out), .state_onehot(state_onehot),
        .state_changed(state_changed), .error(error)
    );

    programmable_state_controller #(.NUM_STATES(16), .IN_W(3), .OUT_W(8)) dut_b (
        .clock(clock), .clear(clear), .start(b_start), .enable(b_enable), .vz(b_vz),
        .cfg_we(b_cfg_we), .cfg_sel(b_cfg_sel), .cfg_addr(b_cfg_addr),
        .cfg_wdata(b_cfg_wdata), .controller_out(b_out), .state_onehot(b_onehot),
        .state_changed(b_chg), .error(b_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model of instance A ----------------
    // State as an integer 0..6, or -1 for IDLE; tables as plain int arrays.
    int m_cur = -1;
    int m_err = 0;
    int m_chg = 0;
    int m_ns [28];
    int m_out[7];

    function automatic int m_next(input int cur);
        int e;
        if (start) return 0;
        if (cur >= 0 && enable) begin
            e = m_ns[cur * 4 + int'(vz)];
            return (e < 7) ? e : -1;
        end
        return cur;
    endfunction

    function automatic int m_next_err(input int cur);
        if (start) return 0;
        if (cur >= 0 && enable && m_ns[cur * 4 + int'(vz)] >= 7) return 1;
        return m_err;
    endfunction

    always @(posedge clock or negedge clear) begin
        if (!clear) begin
            m_cur <= -1;
            m_err <= 0;
            m_chg <= 0;
            for (int i = 0; i < 28; i++) m_ns[i] <= 0;
            for (int i = 0; i < 7; i++) m_out[i] <= 0;
        end else begin
            m_cur <= m_next(m_cur);
            m_err <= m_next_err(m_cur);
            m_chg <= (m_next(m_cur) != m_cur) ? 1 : 0;
            if (cfg_we) begin
                if (cfg_sel == 1'b0 && int'(cfg_addr) / 4 < 7)
                    m_ns[int'(cfg_addr)] <= int'(cfg_wdata) % 8;
                else if (cfg_sel == 1'b1 && int'(cfg_addr) % 8 < 7)
                    m_out[int'(cfg_addr) % 8] <= int'(cfg_wdata);
            end
        end
    end

    always @(negedge clock) begin
        if (check_en) begin
            chk("cmp_onehot", 64'(state_onehot), (m_cur < 0) ? 64'd0 : (64'd1 << m_cur));
            chk("cmp_out", 64'(controller_out), (m_cur < 0) ? 64'd0 : 64'(m_out[m_cur]));
            chk("cmp_changed", 64'(state_changed), 64'(m_chg));
            chk("cmp_error", 64'(error), 64'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    // Every task returns 1 time unit after a falling edge.
    task automatic cyc();
        @(negedge clock);
        #1;
    endtask

    task automatic go(input logic s, input logic e, input logic [1:0] v);
        start = s; enable = e; vz = v;
        cyc();
        start = 1'b0; enable = 1'b0;
    endtask

    task automatic wr(input logic sel, input logic [4:0] addr, input logic [4:0] data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_wdata = data;
        cyc();
        cfg_we = 1'b0;
    endtask

    task automatic wrb(input logic sel, input logic [6:0] addr, input logic [7:0] data);
        b_cfg_we = 1'b1; b_cfg_sel = sel; b_cfg_addr = addr; b_cfg_wdata = data;
        cyc();
        b_cfg_we = 1'b0;
    endtask

    // Legacy table, index = state*4 + vz, A=0 .. G=6.
    int legacy_ns [28] = '{0, 2, 1, 3,   1, 2, 0, 5,   1, 2, 3, 4,   4, 0, 6, 3,
                           5, 6, 0, 4,   6, 0, 1, 2,   0, 6, 6, 1};
    // A=00110 B=10101 C=01110 D=00001 E=10000 F=01000 G=11111
    int legacy_out[7]  = '{6, 21, 14, 1, 16, 8, 31};

    initial begin
        #11;
        chk("reset_onehot", 64'(state_onehot), 64'd0);
        chk("reset_out", 64'(controller_out), 64'd0);
        chk("reset_error", 64'(error), 64'd0);
        clear = 1'b1;
        check_en = 1'b1;

        for (int i = 0; i < 28; i++) wr(1'b0, 5'(i), 5'(legacy_ns[i]));
        for (int i = 0; i < 7; i++) wr(1'b1, 5'(i), 5'(legacy_out[i]));

        // Legacy walk: A -01-> C -00-> B -11-> F.
        go(1'b1, 1'b0, 2'd0);
        chk("start_onehot", 64'(state_onehot), 64'b0000001);
        chk("start_out", 64'(controller_out), 64'b00110);
        chk("start_changed", 64'(state_changed), 64'd1);
        go(1'b1, 1'b0, 2'd0);
        chk("restart_in_a_changed", 64'(state_changed), 64'd0);
        go(1'b0, 1'b1, 2'b01);
        chk("a_to_c_out", 64'(controller_out), 64'b01110);
        chk("a_to_c_changed", 64'(state_changed), 64'd1);
        go(1'b0, 1'b1, 2'b00);
        chk("c_to_b_out", 64'(controller_out), 64'b10101);
        go(1'b0, 1'b1, 2'b11);
        chk("b_to_f_onehot", 64'(state_onehot), 64'b0100000);
        chk("b_to_f_out", 64'(controller_out), 64'b01000);

        // Hold in C with vz cycling.
        go(1'b0, 1'b1, 2'b11);
        for (int v = 0; v < 4; v++) begin
            go(1'b0, 1'b0, 2'(v));
            chk("hold_onehot", 64'(state_onehot), 64'b0000100);
            chk("hold_changed", 64'(state_changed), 64'd0);
        end

        // Out-of-range NS entry taken from A.
        wr(1'b0, 5'b00011, 5'd7);
        go(1'b1, 1'b0, 2'd0);
        go(1'b0, 1'b1, 2'b11);
        chk("illegal_onehot", 64'(state_onehot), 64'd0);
        chk("illegal_out", 64'(controller_out), 64'd0);
        chk("illegal_error", 64'(error), 64'd1);
        go(1'b0, 1'b1, 2'b01);
        chk("idle_sticky_error", 64'(error), 64'd1);
        chk("idle_stays", 64'(state_onehot), 64'd0);
        go(1'b1, 1'b0, 2'd0);
        chk("restart_error", 64'(error), 64'd0);
        chk("restart_onehot", 64'(state_onehot), 64'b0000001);

        // Read-before-write: transition on the write edge uses the old entry.
        start = 1'b0; enable = 1'b1; vz = 2'b01;
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 5'b00001; cfg_wdata = 5'd4;
        cyc();
        cfg_we = 1'b0; enable = 1'b0;
        chk("rbw_old_entry", 64'(state_onehot), 64'b0000100);
        go(1'b1, 1'b0, 2'd0);
        go(1'b0, 1'b1, 2'b01);
        chk("rbw_new_entry", 64'(state_onehot), 64'b0010000);
        chk("e_out", 64'(controller_out), 64'b10000);

        // OUT[cur] rewrite and ignored out-of-range writes.
        wr(1'b1, 5'd4, 5'b11011);
        chk("out_rewrite", 64'(controller_out), 64'b11011);
        wr(1'b1, 5'd7, 5'b11111);
        wr(1'b0, 5'd29, 5'd0);
        chk("oor_write_out", 64'(controller_out), 64'b11011);
        chk("oor_write_error", 64'(error), 64'd0);

        // start wins over enable while in G.
        go(1'b0, 1'b1, 2'b01);
        chk("e_to_g_onehot", 64'(state_onehot), 64'b1000000);
        go(1'b1, 1'b1, 2'b00);
        chk("start_wins_onehot", 64'(state_onehot), 64'b0000001);
        chk("start_wins_out", 64'(controller_out), 64'b00110);

        // Wide parameter set: start overrides enable in state 15.
        wrb(1'b0, 7'd5, 8'd15);
        wrb(1'b1, 7'd0, 8'hA5);
        wrb(1'b1, 7'd15, 8'h3C);
        b_start = 1'b1; cyc(); b_start = 1'b0;
        chk("b_start_out", 64'(b_out), 64'hA5);
        b_enable = 1'b1; b_vz = 3'b101; cyc(); b_enable = 1'b0;
        chk("b_s15_onehot", 64'(b_onehot), 64'h8000);
        chk("b_s15_out", 64'(b_out), 64'h3C);
        b_start = 1'b1; b_enable = 1'b1; cyc(); b_start = 1'b0; b_enable = 1'b0;
        chk("b_start_wins_onehot", 64'(b_onehot), 64'h0001);
        chk("b_start_wins_out", 64'(b_out), 64'hA5);
        chk("b_changed", 64'(b_chg), 64'd1);
        chk("b_error", 64'(b_err), 64'd0);

        // Asynchronous clear between edges, no clock edge before checking.
        #2 clear = 1'b0;
        #1;
        chk("async_onehot", 64'(state_onehot), 64'd0);
        chk("async_out", 64'(controller_out), 64'd0);
        chk("async_changed", 64'(state_changed), 64'd0);
        chk("async_error", 64'(error), 64'd0);
        chk("async_b_onehot", 64'(b_onehot), 64'd0);
        cyc();
        clear = 1'b1;
        for (int v = 0; v < 4; v++) begin
            go(1'b0, 1'b1, 2'(v));
            chk("post_clear_idle", 64'(state_onehot), 64'd0);
        end
        // Tables were cleared: state 0 outputs zero and loops to itself.
        go(1'b1, 1'b0, 2'd0);
        chk("cleared_out", 64'(controller_out), 64'd0);
        go(1'b0, 1'b1, 2'b10);
        chk("cleared_ns", 64'(state_onehot), 64'b0000001);
        chk("cleared_changed", 64'(state_changed), 64'd0);

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
